// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the conv accelerator tile scheduler.
//   - global m/n tile index widths and perf counter width
//   - scheduler state encoding
//   - helper classifying the states that count as waiting on a downstream unit
// -----------------------------------------------------------------------------
package conv_pkg;

  localparam int unsigned M_IDX_W    = 8;
  localparam int unsigned N_IDX_W    = 8;
  localparam int unsigned PERF_CNT_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD_ISSUE = 3'd1,
    ST_LOAD_WAIT  = 3'd2,
    ST_CONV_ISSUE = 3'd3,
    ST_CONV_WAIT  = 3'd4,
    ST_WB_ISSUE   = 3'd5,
    ST_WB_WAIT    = 3'd6,
    ST_FIN        = 3'd7
  } sched_state_t;

  // States in which the scheduler is stalled on data movement (loaders or writeback).
  function automatic logic is_stall_state(input sched_state_t st);
    logic stall;
    case (st)
      ST_LOAD_WAIT: stall = 1'b1;
      ST_WB_WAIT:   stall = 1'b1;
      default:      stall = 1'b0;
    endcase
    return stall;
  endfunction

endpackage

// File: rtl/sched_join2.sv
// -----------------------------------------------------------------------------
// sched_join2
// Two-input completion join. Remembers which of two one-cycle done pulses have
// arrived since the last clear and reports when both have been seen, counting
// pulses that arrive in the current cycle so that simultaneous or early
// completions join without an extra cycle.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clr           clears both seen flags
//   arm           join is active (flags update, all_done/dup evaluated)
//   a_done        one-cycle completion pulse from unit A
//   b_done        one-cycle completion pulse from unit B
//   all_done      both completions seen (including this cycle)
//   dup           a completion arrived for a unit already marked seen
// -----------------------------------------------------------------------------
module sched_join2 (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic arm,
  input  logic a_done,
  input  logic b_done,
  output logic all_done,
  output logic dup
);

  logic a_seen_r;
  logic b_seen_r;

  // Sticky seen flags: cleared on reset or clr, accumulate only while armed.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_seen_r <= 1'b0;
      b_seen_r <= 1'b0;
    end else if (clr) begin
      a_seen_r <= 1'b0;
      b_seen_r <= 1'b0;
    end else if (arm) begin
      a_seen_r <= a_seen_r | a_done;
      b_seen_r <= b_seen_r | b_done;
    end else begin
      a_seen_r <= a_seen_r;
      b_seen_r <= b_seen_r;
    end
  end

  // Same-cycle join and duplicate detection.
  always_comb begin
    all_done = 1'b0;
    dup      = 1'b0;
    if (arm) begin
      all_done = (a_seen_r | a_done) & (b_seen_r | b_done);
      dup      = (a_seen_r & a_done) | (b_seen_r & b_done);
    end else begin
      all_done = 1'b0;
      dup      = 1'b0;
    end
  end

endmodule

// File: rtl/conv_tile_sched.sv
// -----------------------------------------------------------------------------
// conv_tile_sched
// Layer-level tile scheduler for the conv accelerator. For each output-channel
// tile m it walks every input-channel tile n: IFM and weight loaders are kicked
// together, then the conv engine; after the last n of an m the OFM writeback is
// kicked. The shared m/n buses are driven to all four units.
//
// Optional feature (macro CONV_TILE_SCHED_PERF_EN): adds perf_cycles (cycles
// with busy high) and perf_stall (cycles waiting on loaders or writeback),
// both saturating, cleared by reset and by an accepted start.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   start                          one-cycle layer start from host (IDLE only)
//   cfg_m_last, cfg_n_last         tile counts minus one, latched at start
//   busy, done, err                host status (err sticky until next start)
//   m, n                           current tile indices
//   ifm_ld_enable / ifm_ld_done    IFM loader handshake
//   wt_ld_enable / wt_ld_done      weight loader handshake
//   conv_enable / conv_acc_clr / conv_done  conv engine handshake
//   wb_enable / wb_done            OFM writeback handshake
//   perf_cycles, perf_stall        (optional) performance counters
//
// All outputs are registered. Enables are produced from the ISSUE state one
// cycle late, so the enable pulse lands in the first cycle of the matching
// WAIT state; done is registered from the next state so it coincides with FIN.
// -----------------------------------------------------------------------------
module conv_tile_sched
  import conv_pkg::*;
#(
  parameter int M_W = M_IDX_W,
  parameter int N_W = N_IDX_W
`ifdef CONV_TILE_SCHED_PERF_EN
  ,
  parameter int PERF_W = PERF_CNT_W
`endif
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [M_W-1:0] cfg_m_last,
  input  logic [N_W-1:0] cfg_n_last,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [M_W-1:0] m,
  output logic [N_W-1:0] n,
  output logic           ifm_ld_enable,
  input  logic           ifm_ld_done,
  output logic           wt_ld_enable,
  input  logic           wt_ld_done,
  output logic           conv_enable,
  output logic           conv_acc_clr,
  input  logic           conv_done,
  output logic           wb_enable,
  input  logic           wb_done
`ifdef CONV_TILE_SCHED_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_cycles,
  output logic [PERF_W-1:0] perf_stall
`endif
);

  sched_state_t   state_r;
  sched_state_t   state_nxt_s;

  logic [M_W-1:0] m_r;
  logic [N_W-1:0] n_r;
  logic [M_W-1:0] m_last_r;
  logic [N_W-1:0] n_last_r;

  logic           busy_r;
  logic           done_r;
  logic           err_r;
  logic           ifm_en_r;
  logic           wt_en_r;
  logic           conv_en_r;
  logic           acc_clr_r;
  logic           wb_en_r;

  logic           accept_s;
  logic           join_clr_s;
  logic           join_arm_s;
  logic           join_all_s;
  logic           join_dup_s;
  logic           unexp_s;

  assign accept_s   = (state_r == ST_IDLE) && start;
  assign join_clr_s = (state_r == ST_LOAD_ISSUE);
  assign join_arm_s = (state_r == ST_LOAD_WAIT);

  sched_join2 u_load_join (
    .clk      (clk),
    .rst      (rst),
    .clr      (join_clr_s),
    .arm      (join_arm_s),
    .a_done   (ifm_ld_done),
    .b_done   (wt_ld_done),
    .all_done (join_all_s),
    .dup      (join_dup_s)
  );

  // A done pulse is unexpected unless its unit is the one currently awaited;
  // a second loader done within one LOAD_WAIT counts as unexpected too.
  always_comb begin
    unexp_s = 1'b0;
    if (state_r != ST_LOAD_WAIT) begin
      unexp_s = ifm_ld_done | wt_ld_done;
    end else begin
      unexp_s = join_dup_s;
    end
    if (conv_done && (state_r != ST_CONV_WAIT)) begin
      unexp_s = 1'b1;
    end else begin
      unexp_s = unexp_s;
    end
    if (wb_done && (state_r != ST_WB_WAIT)) begin
      unexp_s = 1'b1;
    end else begin
      unexp_s = unexp_s;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; compares use the latched last values so last=0 runs once.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_LOAD_ISSUE;
        else       state_nxt_s = ST_IDLE;
      end
      ST_LOAD_ISSUE: state_nxt_s = ST_LOAD_WAIT;
      ST_LOAD_WAIT: begin
        if (join_all_s) state_nxt_s = ST_CONV_ISSUE;
        else            state_nxt_s = ST_LOAD_WAIT;
      end
      ST_CONV_ISSUE: state_nxt_s = ST_CONV_WAIT;
      ST_CONV_WAIT: begin
        if (!conv_done)          state_nxt_s = ST_CONV_WAIT;
        else if (n_r < n_last_r) state_nxt_s = ST_LOAD_ISSUE;
        else                     state_nxt_s = ST_WB_ISSUE;
      end
      ST_WB_ISSUE: state_nxt_s = ST_WB_WAIT;
      ST_WB_WAIT: begin
        if (!wb_done)            state_nxt_s = ST_WB_WAIT;
        else if (m_r < m_last_r) state_nxt_s = ST_LOAD_ISSUE;
        else                     state_nxt_s = ST_FIN;
      end
      ST_FIN:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Registered outputs, tile indices, latched config and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_r       <= {M_W{1'b0}};
      n_r       <= {N_W{1'b0}};
      m_last_r  <= {M_W{1'b0}};
      n_last_r  <= {N_W{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      ifm_en_r  <= 1'b0;
      wt_en_r   <= 1'b0;
      conv_en_r <= 1'b0;
      acc_clr_r <= 1'b0;
      wb_en_r   <= 1'b0;
    end else begin
      ifm_en_r  <= (state_r == ST_LOAD_ISSUE);
      wt_en_r   <= (state_r == ST_LOAD_ISSUE);
      conv_en_r <= (state_r == ST_CONV_ISSUE);
      acc_clr_r <= (state_r == ST_CONV_ISSUE) && (n_r == {N_W{1'b0}});
      wb_en_r   <= (state_r == ST_WB_ISSUE);
      done_r    <= (state_nxt_s == ST_FIN);
      if (accept_s) begin
        m_last_r <= cfg_m_last;
        n_last_r <= cfg_n_last;
        m_r      <= {M_W{1'b0}};
        n_r      <= {N_W{1'b0}};
        busy_r   <= 1'b1;
        err_r    <= 1'b0;
      end else begin
        if (state_r == ST_FIN) busy_r <= 1'b0;
        if (unexp_s)           err_r  <= 1'b1;
        // Increments are guarded by the compare, so the indices never wrap.
        if ((state_r == ST_CONV_WAIT) && conv_done && (n_r < n_last_r)) begin
          n_r <= n_r + N_W'(1'b1);
        end
        if ((state_r == ST_WB_WAIT) && wb_done && (m_r < m_last_r)) begin
          m_r <= m_r + M_W'(1'b1);
          n_r <= {N_W{1'b0}};
        end
      end
    end
  end

  assign busy          = busy_r;
  assign done          = done_r;
  assign err           = err_r;
  assign m             = m_r;
  assign n             = n_r;
  assign ifm_ld_enable = ifm_en_r;
  assign wt_ld_enable  = wt_en_r;
  assign conv_enable   = conv_en_r;
  assign conv_acc_clr  = acc_clr_r;
  assign wb_enable     = wb_en_r;

`ifdef CONV_TILE_SCHED_PERF_EN
  logic [PERF_W-1:0] perf_cycles_r;
  logic [PERF_W-1:0] perf_stall_r;

  // Saturating perf counters; they stop naturally once busy drops after FIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles_r <= {PERF_W{1'b0}};
      perf_stall_r  <= {PERF_W{1'b0}};
    end else if (accept_s) begin
      perf_cycles_r <= {PERF_W{1'b0}};
      perf_stall_r  <= {PERF_W{1'b0}};
    end else begin
      if (busy_r && (perf_cycles_r != {PERF_W{1'b1}})) begin
        perf_cycles_r <= perf_cycles_r + PERF_W'(1'b1);
      end
      if (is_stall_state(state_r) && (perf_stall_r != {PERF_W{1'b1}})) begin
        perf_stall_r <= perf_stall_r + PERF_W'(1'b1);
      end
    end
  end

  assign perf_cycles = perf_cycles_r;
  assign perf_stall  = perf_stall_r;
`endif

endmodule
